// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// Define MIPS_CTRL_ADDI_EN to add the ADDI_EX/ADDI_WB states for opcode 001000.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ERR      = 4'd10
`ifdef MIPS_CTRL_ADDI_EN
        ,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
`endif
    } state_t;

    // Pure state-decoded controls; input-qualified strobes are added in the top.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        srcb_t      alu_src_b;
        logic [3:0] alu_control;
        pcsrc_t     pc_source;
    } ctrl_t;

    function automatic logic opcode_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t moore_ctrl(input state_t s, input logic [3:0] rtype_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read    = 1'b1;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
                c.pc_source   = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b   = SRCB_IMM_SH2;
                c.alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_MEMREAD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_REG;
                c.alu_control = rtype_alu;
            end
            S_ALUWB: begin
                c.reg_dst     = 1'b1;
                c.reg_write   = 1'b1;
                c.alu_control = rtype_alu;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_REG;
                c.alu_control = ALU_SUB;
                c.pc_source   = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = ALU_ADD;
            end
            S_ADDI_WB: begin
                c.reg_write   = 1'b1;
                c.alu_control = ALU_ADD;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation, with a flag for unsupported funct codes.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-ready stalls and a wait-timeout trap.
// Define MIPS_CTRL_ADDI_EN to support ADDI (opcode 001000); otherwise it is illegal.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TCNT_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic       err,
    output logic [3:0] state_o
);

    state_t            state;
    state_t            next_state;
    ctrl_t             ctrl_q;
    logic [TCNT_W-1:0] tcnt;
    logic              err_q;
    logic [3:0]        rtype_alu;
    logic              funct_illegal;
    logic              waiting;
    logic              timed_out;

    mips_alu_decoder u_alu_dec (
        .funct         (funct),
        .alu_control   (rtype_alu),
        .funct_illegal (funct_illegal)
    );

    assign waiting   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timed_out = waiting && !mem_ready && (tcnt == TCNT_W'(TIMEOUT - 1));

    // A ready on the final allowed wait cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)      next_state = S_DECODE;
                else if (timed_out) next_state = S_ERR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      next_state = S_ADDI_EX;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)      next_state = S_MEMWB;
                else if (timed_out) next_state = S_ERR;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)      next_state = S_FETCH;
                else if (timed_out) next_state = S_ERR;
            end
            S_EXEC:     next_state = funct_illegal ? S_FETCH : S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX:  next_state = S_ADDI_WB;
            S_ADDI_WB:  next_state = S_FETCH;
`endif
            S_ERR:      next_state = S_ERR;
            default:    next_state = S_FETCH;
        endcase
    end

    // Controls are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= moore_ctrl(S_FETCH, ALU_ADD);
            tcnt   <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= next_state;
            ctrl_q <= moore_ctrl(next_state, rtype_alu);
            err_q  <= err_q || (next_state == S_ERR);
            if (next_state != state)
                tcnt <= '0;
            else if (waiting && !mem_ready)
                tcnt <= tcnt + TCNT_W'(1);
        end
    end

    assign pc_write    = !reset && (((state == S_FETCH) && mem_ready) ||
                                    ((state == S_BRANCH) && zero) ||
                                    (state == S_JUMP));
    assign ir_write    = !reset && (state == S_FETCH) && mem_ready;
    assign mem_read    = !reset && ctrl_q.mem_read;
    assign mem_write   = !reset && ctrl_q.mem_write;
    assign reg_write   = !reset && ctrl_q.reg_write;
    assign illegal     = !reset && (((state == S_DECODE) && !opcode_supported(opcode)) ||
                                    ((state == S_EXEC) && funct_illegal));
    assign iord        = ctrl_q.iord;
    assign reg_dst     = ctrl_q.reg_dst;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign alu_control = ctrl_q.alu_control;
    assign pc_source   = ctrl_q.pc_source;
    assign err         = err_q;
    assign state_o     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction streams against a per-instruction cycle model of the control FSM.
// Honors MIPS_CTRL_ADDI_EN the same way as the design.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       illegal, err;
    logic [3:0] state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] asb;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       ill, er;
    } vec_t;

    vec_t obs;
    vec_t full_mask;
    logic [5:0] legal_fns [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};

    assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_control, pc_source, illegal, err};

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT(TO), .TCNT_W(5)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_source(pc_source),
        .illegal(illegal), .err(err), .state_o(state_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        if (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
            op == 6'b000100 || op == 6'b000010) return 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
        if (op == 6'b001000) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Returns {known, alu_code} for an R-type funct.
    function automatic logic [4:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            default:   return 5'b0_0000;
        endcase
    endfunction

    // Entered at posedge+1; drives inputs, checks mid-cycle, leaves at next posedge+1.
    task automatic stepCycle(input string tag, input logic mr, input logic z, input vec_t e, input vec_t m);
        mem_ready = mr;
        zero      = z;
        #2;
        checkOutput(tag, 32'(obs & m), 32'(e & m));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t fetch_vec(input logic ready);
        vec_t e;
        e = '0;
        e.mrd = 1'b1; e.asb = 2'b01; e.alu = 4'b0010;
        e.pcw = ready; e.irw = ready;
        return e;
    endfunction

    // One full instruction: fw not-ready fetch cycles, mw not-ready memory cycles.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int fw, input int mw);
        vec_t       e;
        vec_t       m;
        logic [4:0] a;
        opcode = op;
        funct  = fn;
        for (int i = 0; i <= fw; i++)
            stepCycle("fetch", i == fw, rbit(), fetch_vec(i == fw), full_mask);
        e = '0; e.asb = 2'b11; e.alu = 4'b0010; e.ill = !legal_op(op);
        stepCycle("decode", rbit(), rbit(), e, full_mask);
        if (e.ill) return;
        if (op == 6'b000000) begin
            a = ref_alu(fn);
            e = '0; e.asa = 1'b1; e.alu = a[3:0]; e.ill = !a[4];
            m = full_mask;
            if (!a[4]) m.alu = 4'b0000;
            stepCycle("exec", rbit(), rbit(), e, m);
            if (!a[4]) return;
            e = '0; e.rdst = 1'b1; e.rw = 1'b1; e.alu = a[3:0];
            stepCycle("aluwb", rbit(), rbit(), e, full_mask);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            e = '0; e.asa = 1'b1; e.asb = 2'b10; e.alu = 4'b0010;
            stepCycle("memadr", rbit(), rbit(), e, full_mask);
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.iord = 1'b1;
                if (op == 6'b100011) e.mrd = 1'b1; else e.mwr = 1'b1;
                stepCycle("memacc", i == mw, rbit(), e, full_mask);
            end
            if (op == 6'b100011) begin
                e = '0; e.m2r = 1'b1; e.rw = 1'b1;
                stepCycle("memwb", rbit(), rbit(), e, full_mask);
            end
        end else if (op == 6'b000100) begin
            e = '0; e.asa = 1'b1; e.alu = 4'b0110; e.pcs = 2'b01; e.pcw = z;
            stepCycle("branch", rbit(), z, e, full_mask);
        end else if (op == 6'b000010) begin
            e = '0; e.pcs = 2'b10; e.pcw = 1'b1;
            stepCycle("jump", rbit(), rbit(), e, full_mask);
        end else begin
            e = '0; e.asa = 1'b1; e.asb = 2'b10; e.alu = 4'b0010;
            stepCycle("addi_ex", rbit(), rbit(), e, full_mask);
            e = '0; e.rw = 1'b1; e.alu = 4'b0010;
            stepCycle("addi_wb", rbit(), rbit(), e, full_mask);
        end
    endtask

    initial begin
        vec_t       e;
        int         pick;
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;
        full_mask = '1;
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 6'b0; funct = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_strobes", 32'({pc_write, mem_read, mem_write, ir_write, reg_write, illegal}), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_state", 32'(state_o), 32'(S_FETCH));
        reset = 1'b0;

        applyStimulus(6'b000000, 6'b100010, 1'b0, 0, 0);
        applyStimulus(6'b100011, 6'b000000, 1'b0, 0, 3);
        applyStimulus(6'b000100, 6'b000000, 1'b1, 0, 0);
        applyStimulus(6'b000100, 6'b000000, 1'b0, 0, 0);
        applyStimulus(6'b111111, 6'b100000, 1'b0, 0, 0);
        applyStimulus(6'b001000, 6'b000000, 1'b0, 0, 0);
        applyStimulus(6'b101011, 6'b000000, 1'b0, 0, TO - 1);
        applyStimulus(6'b000000, 6'b111000, 1'b0, TO - 1, 0);

        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0, 1:    op = 6'b000000;
                2:       op = 6'b100011;
                3:       op = 6'b101011;
                4:       op = 6'b000100;
                5:       op = 6'b000010;
                6:       op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 3)];
            fw = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            applyStimulus(op, fn, rbit(), fw, mw);
        end

        opcode = 6'b000000;
        for (int i = 0; i < TO; i++)
            stepCycle("fetch_wait", 1'b0, rbit(), fetch_vec(1'b0), full_mask);
        e = '0; e.er = 1'b1;
        for (int i = 0; i < 3; i++)
            stepCycle("err_hold", 1'b1, 1'b1, e, full_mask);
        checkOutput("err_state", 32'(state_o), 32'(S_ERR));

        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_err", 32'(err), 32'd0);
        checkOutput("async_rst_state", 32'(state_o), 32'(S_FETCH));
        checkOutput("async_rst_strobes", 32'({pc_write, mem_read, mem_write, ir_write, reg_write, illegal}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1, 0);
        stepCycle("final_fetch", 1'b0, 1'b0, fetch_vec(1'b0), full_mask);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
